// File: rtl/omsp_clk_en_gen.sv
// omsp_clk_en_gen - NCH programmable clock-enable channels for the openMSP430
// peripheral space. Each channel counts ticks of MCLK or of the LFXT rising
// edge and emits a one-cycle enable every DIV+1 ticks (continuous or one-shot).
// Build option: CLKEN_LFXT_SYNC_EN adds a 2-flop synchroniser on lfxt_clk;
// without it lfxt_clk is assumed synchronous to mclk.
module omsp_clk_en_gen #(
    parameter logic [14:0] BASE_ADDR = 15'h0100,
    parameter int          DEC_WD    = 4,
    parameter int          NCH       = 4,
    parameter int          DIV_WD    = 8
) (
    input  logic            mclk,
    input  logic            puc_rst,
    input  logic            cpu_en_s,
    input  logic            lfxt_clk,
    input  logic [13:0]     per_addr,
    input  logic [15:0]     per_din,
    input  logic            per_en,
    input  logic [1:0]      per_we,
    output logic [15:0]     per_dout,
    output logic [NCH-1:0]  clk_en
);

    localparam int IDX_WD = DEC_WD - 1;

    // Address decode shared by every channel
    logic              w_reg_sel;
    logic [IDX_WD-1:0] w_idx;
    logic              w_wr;
    logic              w_rd;

    assign w_reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign w_idx     = per_addr[IDX_WD-1:0];
    assign w_wr      = w_reg_sel & (per_we != 2'b00);
    assign w_rd      = w_reg_sel & (per_we == 2'b00);

    // LFXT level as seen in the mclk domain
    logic w_lfxt_s;
    logic r_lfxt_dly;
    logic w_lfxt_tick;

`ifdef CLKEN_LFXT_SYNC_EN
    logic [1:0] r_lfxt_sync;

    // Two-flop synchroniser bringing lfxt_clk into the mclk domain
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_lfxt_sync <= 2'b00;
        end else begin
            r_lfxt_sync <= {r_lfxt_sync[0], lfxt_clk};
        end
    end

    assign w_lfxt_s = r_lfxt_sync[1];
`else
    assign w_lfxt_s = lfxt_clk;
`endif

    // One-mclk delay of the LFXT level for rising-edge detection
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_lfxt_dly <= 1'b0;
        end else begin
            r_lfxt_dly <= w_lfxt_s;
        end
    end

    assign w_lfxt_tick = w_lfxt_s & ~r_lfxt_dly;

    // Current register image of each channel, used for readback and byte merge
    logic [15:0] w_cur [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [DIV_WD-1:0] r_div;
        logic [DIV_WD-1:0] r_cnt;
        logic              r_sel;
        logic              r_oneshot;
        logic              r_en;
        logic              r_clk_en;
        logic              w_wr_ch;
        logic              w_tick;
        logic              w_term;
        logic [15:0]       w_merged;
        logic              w_unused_merged;

        assign w_cur[gi] = {r_en, r_oneshot, r_sel, 13'(r_div)};
        assign w_wr_ch   = w_wr & (w_idx == IDX_WD'(gi));
        // Bytes not enabled keep their current content
        assign w_merged  = {per_we[1] ? per_din[15:8] : w_cur[gi][15:8],
                            per_we[0] ? per_din[7:0]  : w_cur[gi][7:0]};
        // Bits between DIV and SEL are write-masked
        assign w_unused_merged = ^w_merged[12:DIV_WD];
        assign w_tick    = r_en & cpu_en_s & (r_sel ? w_lfxt_tick : 1'b1);
        assign w_term    = (r_cnt == r_div);

        // Channel control, divider counter and registered enable pulse;
        // a register write restarts the count and beats a coincident pulse
        always_ff @(posedge mclk) begin
            if (puc_rst) begin
                r_div     <= {DIV_WD{1'b0}};
                r_cnt     <= {DIV_WD{1'b0}};
                r_sel     <= 1'b0;
                r_oneshot <= 1'b0;
                r_en      <= 1'b0;
                r_clk_en  <= 1'b0;
            end else if (w_wr_ch) begin
                r_div     <= w_merged[DIV_WD-1:0];
                r_sel     <= w_merged[13];
                r_oneshot <= w_merged[14];
                r_en      <= w_merged[15];
                r_cnt     <= {DIV_WD{1'b0}};
                r_clk_en  <= 1'b0;
            end else if (w_tick) begin
                if (w_term) begin
                    r_cnt    <= {DIV_WD{1'b0}};
                    r_clk_en <= 1'b1;
                    if (r_oneshot) begin
                        r_en <= 1'b0;
                    end
                end else begin
                    r_cnt    <= r_cnt + DIV_WD'(1);
                    r_clk_en <= 1'b0;
                end
            end else begin
                r_clk_en <= 1'b0;
            end
        end

        assign clk_en[gi] = r_clk_en;
    end

    // Combinational readback; unimplemented indices and non-reads give 0
    always_comb begin
        per_dout = 16'h0000;
        for (int i = 0; i < NCH; i++) begin
            per_dout = per_dout |
                       ((w_rd && (w_idx == IDX_WD'(i))) ? w_cur[i] : 16'h0000);
        end
    end

endmodule

// File: tb/tb_omsp_clk_en_gen.sv
// Self-checking bench for omsp_clk_en_gen: a behavioural register/period model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_omsp_clk_en_gen;

    localparam int          NCH        = 4;
    localparam int          DIV_WD     = 8;
    localparam logic [13:0] BASE_WADDR = 14'h0080;
    localparam logic [15:0] REG_MASK   = 16'hE0FF;
`ifdef CLKEN_LFXT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic           mclk = 1'b0;
    logic           puc_rst;
    logic           cpu_en_s;
    logic           lfxt_clk;
    logic [13:0]    per_addr;
    logic [15:0]    per_din;
    logic           per_en;
    logic [1:0]     per_we;
    logic [15:0]    per_dout;
    logic [NCH-1:0] clk_en;

    omsp_clk_en_gen #(
        .BASE_ADDR (15'h0100),
        .DEC_WD    (4),
        .NCH       (NCH),
        .DIV_WD    (DIV_WD)
    ) dut (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .cpu_en_s (cpu_en_s),
        .lfxt_clk (lfxt_clk),
        .per_addr (per_addr),
        .per_din  (per_din),
        .per_en   (per_en),
        .per_we   (per_we),
        .per_dout (per_dout),
        .clk_en   (clk_en)
    );

    always #5 mclk = ~mclk;

    // Reference model state: register images, tick counts, expected pulses
    logic [15:0]    m_reg [NCH];
    int             m_cnt [NCH];
    logic [NCH-1:0] m_ce;
    logic [3:0]     m_lh;
    int             n_chk  = 0;
    int             n_pass = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic addr_hit();
        return per_en && (per_addr[13:3] == BASE_WADDR[13:3]);
    endfunction

    function automatic logic [15:0] m_read();
        if (addr_hit() && per_we == 2'b00 && int'(per_addr[2:0]) < NCH)
            return m_reg[int'(per_addr[2:0])];
        else
            return 16'h0000;
    endfunction

    // Advance the model by one mclk edge using the inputs present at that edge
    task automatic model_edge();
        logic ltick;
        if (puc_rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_reg[i] = 16'h0000;
                m_cnt[i] = 0;
            end
            m_ce = '0;
            m_lh = 4'h0;
        end else begin
            m_lh  = {m_lh[2:0], lfxt_clk};
            ltick = m_lh[LAT] & ~m_lh[LAT+1];
            for (int i = 0; i < NCH; i++) begin
                if (addr_hit() && per_we != 2'b00 && int'(per_addr[2:0]) == i) begin
                    m_reg[i] = {per_we[1] ? per_din[15:8] : m_reg[i][15:8],
                                per_we[0] ? per_din[7:0]  : m_reg[i][7:0]} & REG_MASK;
                    m_cnt[i] = 0;
                    m_ce[i]  = 1'b0;
                end else if (m_reg[i][15] && cpu_en_s && (!m_reg[i][13] || ltick)) begin
                    if (m_cnt[i] == int'(m_reg[i][DIV_WD-1:0])) begin
                        m_cnt[i] = 0;
                        m_ce[i]  = 1'b1;
                        if (m_reg[i][14]) m_reg[i][15] = 1'b0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                        m_ce[i]  = 1'b0;
                    end
                end else begin
                    m_ce[i] = 1'b0;
                end
            end
        end
    endtask

    // One clock: model update at the edge, DUT compare on the falling edge
    task automatic cyc();
        @(posedge mclk);
        model_edge();
        @(negedge mclk);
        check("model_clk_en", {12'h000, clk_en}, {12'h000, m_ce});
        check("model_per_dout", per_dout, m_read());
    endtask

    task automatic drv_idle();
        per_en = 1'b0; per_we = 2'b00; per_addr = 14'h0000; per_din = 16'h0000;
    endtask

    task automatic drv_wr(input int idx, input logic [15:0] v, input logic [1:0] we);
        per_en = 1'b1; per_we = we; per_addr = BASE_WADDR | 14'(idx); per_din = v;
    endtask

    task automatic drv_rd(input int idx);
        per_en = 1'b1; per_we = 2'b00; per_addr = BASE_WADDR | 14'(idx); per_din = 16'h0000;
    endtask

    initial begin
        int pulses;
        int r;
        puc_rst = 1'b1; cpu_en_s = 1'b1; lfxt_clk = 1'b0;
        drv_idle();
        cyc(); cyc();
        puc_rst = 1'b0;

        // Reset state: all registers read 0, no enables
        for (int i = 0; i < NCH; i++) begin
            drv_rd(i);
            cyc();
            check("reset_read", per_dout, 16'h0000);
        end
        check("reset_clk_en", {12'h000, clk_en}, 16'h0000);

        // DIV=3 continuous: pulse after edges E0+4, E0+8, E0+12
        drv_wr(0, 16'h8003, 2'b11);
        cyc();
        drv_idle();
        for (int n = 1; n <= 12; n++) begin
            cyc();
            check("div3_pulse", {15'h0000, clk_en[0]}, {15'h0000, (n % 4) == 0});
        end

        // Low-byte rewrite on the terminal cycle suppresses the pulse
        drv_wr(0, 16'h8003, 2'b11);
        cyc();
        drv_idle();
        cyc(); cyc(); cyc();
        drv_wr(0, 16'h0003, 2'b01);
        cyc();
        check("rewrite_no_pulse", {15'h0000, clk_en[0]}, 16'h0000);
        for (int n = 1; n <= 4; n++) begin
            if (n == 1) drv_rd(0); else drv_idle();
            cyc();
            if (n == 1) check("rewrite_readback", per_dout, 16'h8003);
            check("rewrite_next_pulse", {15'h0000, clk_en[0]}, {15'h0000, n == 4});
        end

        // Unimplemented index: write ignored, reads 0
        drv_wr(NCH, 16'hFFFF, 2'b11);
        cyc();
        drv_rd(NCH);
        cyc();
        check("unimpl_read", per_dout, 16'h0000);
        drv_rd(0);
        cyc();
        check("unimpl_ch0_kept", per_dout, 16'h8003);
        drv_rd(3);
        cyc();
        check("unimpl_ch3_kept", per_dout, 16'h0000);

        // cpu_en_s pause at DIV=7: period is 8 active cycles
        drv_wr(2, 16'h8007, 2'b11);
        cyc();
        drv_idle();
        cyc(); cyc(); cyc();
        cpu_en_s = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cyc();
            check("pause_clk_en", {12'h000, clk_en}, 16'h0000);
        end
        cpu_en_s = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            cyc();
            check("resume_pulse", {15'h0000, clk_en[2]}, {15'h0000, n == 5});
        end

        // One-shot on LFXT edges, DIV=1: exactly one pulse, EN self-clears
        drv_wr(1, 16'hE001, 2'b11);
        cyc();
        drv_idle();
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            lfxt_clk = ((k / 4) % 2) == 1;
            cyc();
            pulses += int'(clk_en[1]);
        end
        check("oneshot_pulses", 16'(pulses), 16'd1);
        drv_rd(1);
        cyc();
        check("oneshot_readback", per_dout, 16'h6001);
        lfxt_clk = 1'b0;

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                drv_wr($urandom_range(0, 7),
                       {8'($urandom_range(0, 255)), 8'($urandom_range(0, 5))},
                       2'($urandom_range(1, 3)));
            end else if (r < 35) begin
                drv_rd($urandom_range(0, 7));
            end else if (r < 40) begin
                per_en = 1'b1; per_we = 2'($urandom_range(0, 3));
                per_addr = 14'h0090 | 14'($urandom_range(0, 7));
                per_din = 16'($urandom);
            end else begin
                drv_idle();
            end
            cpu_en_s = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) lfxt_clk = ~lfxt_clk;
            puc_rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        puc_rst = 1'b0; cpu_en_s = 1'b1; lfxt_clk = 1'b0;
        drv_idle();

        // Reset mid-count clears everything on the next edge
        drv_wr(0, 16'h8003, 2'b11);
        cyc();
        drv_idle();
        cyc(); cyc();
        puc_rst = 1'b1;
        drv_rd(0);
        cyc();
        check("midreset_clk_en", {12'h000, clk_en}, 16'h0000);
        check("midreset_read", per_dout, 16'h0000);
        puc_rst = 1'b0;
        drv_idle();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
